fadd_issue: RTL

- Upstream operand-issue stage for the 3-stage pipelined 16-bit float adder.
- Format: sign [15], biased exponent [14:7] (bias 127), mantissa [6:0] with hidden 1.
- Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Resolves trivial cases (zero operand, exact cancellation) locally; issues everything else to the adder.
- Merges bypassed and adder results back into a single in-order result stream.

---
 rtl/fadd_issue_if.sv | 30 +++
 rtl/fadd_issue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fadd_issue_if.sv
// Operand/result bundle between the issue stage and its environment.
//   in_valid/in_ready/in_a/in_b : operand-pair handshake into the issue FIFO
//   op_a/op_b/op_valid          : operands presented to the pipelined adder
//   add_sum                     : adder result, LAT edges after presentation
//   out_valid/out_sum           : merged in-order result stream
// slave modport is the issue stage; master is whatever surrounds it.
interface fadd_issue_if #(
  parameter int unsigned N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         op_valid;
  logic [N-1:0] add_sum;
  logic         out_valid;
  logic [N-1:0] out_sum;

  modport slave (
    input  in_valid, in_a, in_b, add_sum,
    output in_ready, op_a, op_b, op_valid, out_valid, out_sum
  );

  modport master (
    output in_valid, in_a, in_b, add_sum,
    input  in_ready, op_a, op_b, op_valid, out_valid, out_sum
  );
endinterface

// File: rtl/fadd_issue.sv
// Operand-issue stage for a pipelined 16-bit float adder.
// Buffers operand pairs in a small FIFO, pops one pair per cycle, resolves trivial
// sums (zero operand, exact cancellation) locally and sends the rest to the adder.
// A tag pipeline of LAT+1 slots tracks every popped pair so bypassed and adder
// results rejoin the output stream in acceptance order with identical latency.
// Ports:
//   clock, nreset : rising-edge clock, asynchronous active-low reset
//   bus           : fadd_issue_if.slave (input handshake, adder side, result stream)
//   stat_issued, stat_bypassed : saturating counters, only when FADD_ISSUE_STATS_EN
//                                is defined
module fadd_issue #(
  parameter int unsigned N      = 16,
  parameter int unsigned EXP_HI = 14,
  parameter int unsigned MAN_HI = 6,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LAT    = 3
) (
  input  logic         clock,
  input  logic         nreset,
  fadd_issue_if.slave  bus
`ifdef FADD_ISSUE_STATS_EN
  ,
  output logic [15:0]  stat_issued,
  output logic [15:0]  stat_bypassed
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic         busy;
    logic         bypass;
    logic [N-1:0] value;
  } tag_t;

  logic [2*N-1:0] mem_q [DEPTH];
  logic [2*N-1:0] mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  tag_t tag_q [LAT+1];
  tag_t tag_d [LAT+1];

  logic [N-1:0] op_a_q, op_a_d;
  logic [N-1:0] op_b_q, op_b_d;
  logic         op_valid_q, op_valid_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_sum_q, out_sum_d;

  logic         push, pop;
  logic [N-1:0] head_a, head_b;
  logic         a_zero, b_zero, cancel, bypass;
  logic [N-1:0] bypass_val;

  assign bus.in_ready  = (count_q < CntW'(DEPTH));
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;

  assign push = bus.in_valid && bus.in_ready;
  // The head is drained every cycle it exists; there is no downstream stall.
  assign pop  = (count_q != '0);

  assign head_a = mem_q[rd_ptr_q][2*N-1:N];
  assign head_b = mem_q[rd_ptr_q][N-1:0];

  // Zero is decided on the exponent alone; denormal mantissas are ignored.
  assign a_zero = (head_a[EXP_HI:MAN_HI+1] == '0);
  assign b_zero = (head_b[EXP_HI:MAN_HI+1] == '0);
  assign cancel = (head_a[N-2:0] == head_b[N-2:0]) && (head_a[N-1] != head_b[N-1]);
  assign bypass = a_zero || b_zero || cancel;

  always_comb begin
    bypass_val = '0;
    if (a_zero && !b_zero) begin
      bypass_val = head_b;
    end else if (b_zero && !a_zero) begin
      bypass_val = head_a;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.in_a, bus.in_b};
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_comb begin
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = 1'b0;
    if (pop && !bypass) begin
      op_a_d     = head_a;
      op_b_d     = head_b;
      op_valid_d = 1'b1;
    end
  end

  always_comb begin
    tag_d[0] = '{busy: pop, bypass: bypass, value: bypass_val};
    for (int i = 1; i <= LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // The last tag slot lines up with add_sum for its own pair.
  always_comb begin
    out_valid_d = tag_q[LAT].busy;
    out_sum_d   = out_sum_q;
    if (tag_q[LAT].busy) begin
      out_sum_d = tag_q[LAT].bypass ? tag_q[LAT].value : bus.add_sum;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      for (int i = 0; i <= LAT; i++) begin
        tag_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      mem_q       <= mem_d;
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_valid_q  <= op_valid_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
    end
  end

`ifdef FADD_ISSUE_STATS_EN
  logic [15:0] issued_q, issued_d;
  logic [15:0] bypassed_q, bypassed_d;

  always_comb begin
    issued_d   = issued_q;
    bypassed_d = bypassed_q;
    if (pop && !bypass && (issued_q != 16'hFFFF)) begin
      issued_d = issued_q + 16'd1;
    end
    if (pop && bypass && (bypassed_q != 16'hFFFF)) begin
      bypassed_d = bypassed_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      issued_q   <= '0;
      bypassed_q <= '0;
    end else begin
      issued_q   <= issued_d;
      bypassed_q <= bypassed_d;
    end
  end

  assign stat_issued   = issued_q;
  assign stat_bypassed = bypassed_q;
`endif

endmodule
